// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the systolic MAC processing element.
//   DEFAULT_DATA_W / DEFAULT_ACC_W : default operand and partial-sum widths
//   psum_t                         : partial-sum word at the default width
//   sat_add()                      : width-generic add with overflow detect
//                                    and optional clamp, returns {ovf, sum}
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package mac_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ACC_W  = 24;
    localparam int MAX_ACC_W      = 64;

    typedef logic [DEFAULT_ACC_W-1:0] psum_t;
    typedef logic [MAX_ACC_W-1:0]     wide_t;

    typedef struct packed {
        logic  ovf;
        wide_t sum;
    } sat_result_t;

    // Operands live in the low acc_w bits of a wide word. The sum is formed
    // one bit wider than acc_w so the unsigned carry is directly visible.
    // The signed rule is the classic "same-sign operands, different-sign
    // result" test; the clamp direction follows the operand sign.
    function automatic sat_result_t sat_add(input wide_t a,
                                            input wide_t b,
                                            input int    acc_w,
                                            input logic  signed_mode,
                                            input logic  saturate);
        logic [MAX_ACC_W:0] raw;
        wide_t              mask;
        wide_t              max_pos;
        wide_t              min_neg;
        wide_t              clamp;
        logic               sa;
        logic               sb;
        logic               sr;
        sat_result_t        r;

        mask    = (acc_w >= MAX_ACC_W) ? '1 : ((wide_t'(1) << acc_w) - wide_t'(1));
        max_pos = mask >> 1;
        min_neg = mask ^ max_pos;
        raw     = {1'b0, a & mask} + {1'b0, b & mask};
        sa      = a[acc_w-1];
        sb      = b[acc_w-1];
        sr      = raw[acc_w-1];

        if (signed_mode) begin
            r.ovf = (sa == sb) && (sr != sa);
            clamp = sa ? min_neg : max_pos;
        end else begin
            r.ovf = raw[acc_w];
            clamp = mask;
        end

        r.sum = (r.ovf && saturate) ? clamp : (raw[MAX_ACC_W-1:0] & mask);
        return r;
    endfunction

endpackage

// File: rtl/mac_sat_adder.sv
// ---------------------------------------------------------------------------
// mac_sat_adder
// Combinational stage-2 adder of the MAC PE: adds the extended product to the
// incoming partial sum, flags overflow and optionally clamps.
// Ports:
//   a    in  ACC_W  extended product
//   b    in  ACC_W  partial sum
//   sum  out ACC_W  clamped or wrapped result
//   ovf  out 1      overflow occurred for this addition
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module mac_sat_adder
    import mac_pkg::*;
#(
    parameter int ACC_W    = DEFAULT_ACC_W,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    sat_result_t res;

    always_comb begin
        res = sat_add(wide_t'(a), wide_t'(b), ACC_W, (SIGNED != 0), (SATURATE != 0));
    end

    assign sum = ACC_W'(res.sum);
    assign ovf = res.ovf;

endmodule

// File: rtl/mac_pe_param.sv
// ---------------------------------------------------------------------------
// mac_pe_param
// Parametrised systolic processing element: psum_out = psum_in + a_in * w.
// Double-buffered weights, 2-stage pipeline, optional saturation, valid
// tracking. Activations go east, weights and partial sums go south.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   a_in/a_valid_in activation from west and MAC qualifier
//   psum_in         partial sum from north
//   w_in            weight from north preload chain
//   w_load/w_swap   capture into shadow / promote shadow to active
//   sat_clr         clear sticky sat_flag
//   a_out/a_valid_out registered activation to east
//   w_out           shadow weight to south
//   psum_out/psum_valid_out  MAC result and its "new this cycle" strobe
//   sat_flag        sticky overflow indicator
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module mac_pe_param
    import mac_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ACC_W    = DEFAULT_ACC_W,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_valid_in,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_load,
    input  logic              w_swap,
    input  logic              sat_clr,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid_out,
    output logic [DATA_W-1:0] w_out,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_valid_out,
    output logic              sat_flag
);

    logic [DATA_W-1:0]   shadow_w;
    logic [DATA_W-1:0]   active_w;
    logic [2*DATA_W-1:0] prod_next;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    psum_s1;
    logic [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]    sum;
    logic                v1;
    logic                ovf;

    // Operands are widened to the full product width before multiplying so
    // the product is exact in both signed and unsigned modes.
    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [2*DATA_W-1:0] a_ext;
            logic signed [2*DATA_W-1:0] w_ext;
            assign a_ext     = (2*DATA_W)'($signed(a_in));
            assign w_ext     = (2*DATA_W)'($signed(active_w));
            assign prod_next = a_ext * w_ext;
            assign prod_ext  = ACC_W'($signed(prod));
        end else begin : g_unsigned
            logic [2*DATA_W-1:0] a_ext;
            logic [2*DATA_W-1:0] w_ext;
            assign a_ext     = (2*DATA_W)'(a_in);
            assign w_ext     = (2*DATA_W)'(active_w);
            assign prod_next = a_ext * w_ext;
            assign prod_ext  = ACC_W'(prod);
        end
    endgenerate

    mac_sat_adder #(
        .ACC_W    (ACC_W),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_adder (
        .a   (prod_ext),
        .b   (psum_s1),
        .sum (sum),
        .ovf (ovf)
    );

    // Weight double buffer: a simultaneous load and swap promotes the old
    // shadow value while the shadow captures the new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_w <= '0;
            active_w <= '0;
        end else begin
            if (w_load) shadow_w <= w_in;
            if (w_swap) active_w <= shadow_w;
        end
    end

    assign w_out = shadow_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out       <= '0;
            a_valid_out <= 1'b0;
        end else begin
            a_out       <= a_in;
            a_valid_out <= a_valid_in;
        end
    end

    // Stage 1 uses the active weight as it was before this edge, so a swap
    // in the same cycle only affects later MACs. Data regs hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod    <= '0;
            psum_s1 <= '0;
            v1      <= 1'b0;
        end else begin
            v1 <= a_valid_in;
            if (a_valid_in) begin
                prod    <= prod_next;
                psum_s1 <= psum_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
        end else begin
            psum_valid_out <= v1;
            if (v1) psum_out <= sum;
        end
    end

    // Overflow is only meaningful for a real MAC; the held stage-1 values
    // would otherwise keep re-setting the flag after a clear. Set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (v1 && ovf) begin
            sat_flag <= 1'b1;
        end else if (sat_clr) begin
            sat_flag <= 1'b0;
        end
    end

endmodule
